// File: rtl/exception_vector_reader.sv
// Exception vector fetch helper for the multicycle controller.
// Latency: select at ADDR, capture after MEM_LAT read cycles, pc_wr/exc_done MEM_LAT+1 cycles after ADDR.
// Backpressure: none; requests are sampled only in IDLE and dropped while busy (no queueing).
//
// Ports:
//   i_clock          system clock, rising edge
//   i_reset_n        asynchronous active-low reset
//   i_exc_req        exception request from the control FSM (sampled only in IDLE)
//   i_exc_cause      01 overflow, 10 invalid opcode, 11 divide-by-zero, 00 none
//   i_mem_data_in    memory read data; only bits 7:0 are used
//   o_mux_mem_end    memory-address mux select: 000 PC, 010 @255, 011 @254, 100 @253
//   o_mem_wr         memory write enable, always 0
//   o_epc_wr         one-cycle strobe in the ADDR cycle: control latches EPC
//   o_pc_wr          one-cycle strobe in the DONE cycle: PC loads o_handler_pc
//   o_handler_pc     zero-extended handler byte, held until the next capture
//   o_busy           high from ADDR through DONE
//   o_exc_done       one-cycle completion pulse, coincident with o_pc_wr
module exception_vector_reader #(
  parameter int MEM_LAT = 2
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_exc_req,
  input  logic [1:0]  i_exc_cause,
  input  logic [31:0] i_mem_data_in,
  output logic [2:0]  o_mux_mem_end,
  output logic        o_mem_wr,
  output logic        o_epc_wr,
  output logic        o_pc_wr,
  output logic [31:0] o_handler_pc,
  output logic        o_busy,
  output logic        o_exc_done
);

  localparam int CW = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_cause;
  logic [1:0]      w_cause_nxt;
  logic            w_accept;
  logic [2:0]      r_sel;
  logic [2:0]      w_sel_nxt;
  logic            r_epc_wr;
  logic            w_epc_wr_nxt;
  logic            r_done;
  logic            w_done_nxt;
  logic            r_busy;
  logic            w_busy_nxt;
  logic [31:0]     r_handler_pc;
  logic            w_unused_hi;

  // Upper bytes of the read bus carry nothing for this block.
  assign w_unused_hi = ^i_mem_data_in[31:8];

  assign w_accept    = (r_state == S_IDLE) && i_exc_req && (i_exc_cause != 2'b00);
  // On the accepting edge the latch has not updated yet, so the select for
  // the ADDR cycle must come straight from the incoming cause.
  assign w_cause_nxt = w_accept ? i_exc_cause : r_cause;

  function automatic logic [2:0] vector_sel(input logic [1:0] cause);
    case (cause)
      2'b01:   vector_sel = 3'b010;  // overflow       -> byte 255
      2'b10:   vector_sel = 3'b011;  // invalid opcode -> byte 254
      2'b11:   vector_sel = 3'b100;  // divide by zero -> byte 253
      default: vector_sel = 3'b000;
    endcase
  endfunction

  // State register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_nxt = S_ADDR;
      S_ADDR:    w_state_nxt = (MEM_LAT == 1) ? S_CAPTURE : S_WAIT;
      S_WAIT:    if (r_cnt == '0) w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: decoded from the next state so every output is a flop
  // that switches together with the state it belongs to.
  always_comb begin
    w_sel_nxt    = 3'b000;
    w_epc_wr_nxt = 1'b0;
    w_done_nxt   = 1'b0;
    w_busy_nxt   = 1'b0;
    case (w_state_nxt)
      S_ADDR: begin
        w_sel_nxt    = vector_sel(w_cause_nxt);
        w_epc_wr_nxt = 1'b1;
        w_busy_nxt   = 1'b1;
      end
      S_WAIT, S_CAPTURE: begin
        w_sel_nxt  = vector_sel(w_cause_nxt);
        w_busy_nxt = 1'b1;
      end
      S_DONE: begin
        w_done_nxt = 1'b1;
        w_busy_nxt = 1'b1;
      end
      default: begin
        w_sel_nxt = 3'b000;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sel    <= 3'b000;
      r_epc_wr <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_sel    <= w_sel_nxt;
      r_epc_wr <= w_epc_wr_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  // Wait counter: loaded on accept so it reads MEM_LAT-1 during ADDR, then
  // counts down through ADDR and WAIT. WAIT exits when it reaches zero,
  // giving ADDR + (MEM_LAT-1) WAIT cycles before CAPTURE.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= CW'(MEM_LAT - 1);
    end else if ((r_state == S_ADDR || r_state == S_WAIT) && r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cause      <= 2'b00;
      r_handler_pc <= 32'd0;
    end else begin
      if (w_accept) begin
        r_cause <= i_exc_cause;
      end
      if (r_state == S_CAPTURE) begin
        r_handler_pc <= {24'd0, i_mem_data_in[7:0]};
      end
    end
  end

  assign o_mux_mem_end = r_sel;
  assign o_mem_wr      = 1'b0;
  assign o_epc_wr      = r_epc_wr;
  assign o_pc_wr       = r_done;
  assign o_exc_done    = r_done;
  assign o_busy        = r_busy;
  assign o_handler_pc  = r_handler_pc;

endmodule

// File: tb/tb_exception_vector_reader.sv
// Bench for exception_vector_reader: three builds (MEM_LAT 2, 1, 5) share one
// input stream; a per-build timeline model predicts every output each cycle.
// Outputs are sampled 1ns after the rising edge, inputs change right after.
module tb_exception_vector_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [1:0]  cause;
  logic [31:0] mdat;

  logic [2:0]  o_sel  [3];
  logic        o_memwr[3];
  logic        o_epc  [3];
  logic        o_pc   [3];
  logic        o_done [3];
  logic        o_busy [3];
  logic [31:0] o_hp   [3];

  // Model: ph = cycles since acceptance (0 = first busy cycle), -1 = idle.
  int          ph   [3];
  logic [1:0]  mc   [3];
  logic [31:0] mhp  [3];
  int          mdone[3];
  int          ndone[3];
  int          snap [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  exception_vector_reader #(.MEM_LAT(2)) u_lat2 (
    .i_clock(clk), .i_reset_n(rst_n), .i_exc_req(req), .i_exc_cause(cause),
    .i_mem_data_in(mdat), .o_mux_mem_end(o_sel[0]), .o_mem_wr(o_memwr[0]),
    .o_epc_wr(o_epc[0]), .o_pc_wr(o_pc[0]), .o_handler_pc(o_hp[0]),
    .o_busy(o_busy[0]), .o_exc_done(o_done[0]));

  exception_vector_reader #(.MEM_LAT(1)) u_lat1 (
    .i_clock(clk), .i_reset_n(rst_n), .i_exc_req(req), .i_exc_cause(cause),
    .i_mem_data_in(mdat), .o_mux_mem_end(o_sel[1]), .o_mem_wr(o_memwr[1]),
    .o_epc_wr(o_epc[1]), .o_pc_wr(o_pc[1]), .o_handler_pc(o_hp[1]),
    .o_busy(o_busy[1]), .o_exc_done(o_done[1]));

  exception_vector_reader #(.MEM_LAT(5)) u_lat5 (
    .i_clock(clk), .i_reset_n(rst_n), .i_exc_req(req), .i_exc_cause(cause),
    .i_mem_data_in(mdat), .o_mux_mem_end(o_sel[2]), .o_mem_wr(o_memwr[2]),
    .o_epc_wr(o_epc[2]), .o_pc_wr(o_pc[2]), .o_handler_pc(o_hp[2]),
    .o_busy(o_busy[2]), .o_exc_done(o_done[2]));

  function automatic int lat_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 5;
    endcase
  endfunction

  // Vector byte addresses 255/254/253 map to select codes 2/3/4.
  function automatic logic [2:0] sel_of(input logic [1:0] c);
    logic [2:0] tbl [4];
    tbl = '{3'd0, 3'd2, 3'd3, 3'd4};
    return tbl[c];
  endfunction

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s lat%0d observed=0x%0h expected=0x%0h", tag, lat_of(idx), obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      ph[i]  = -1;
      mc[i]  = 2'b00;
      mhp[i] = 32'd0;
    end
  endtask

  // Advance every build's timeline by one rising edge using the inputs
  // that were stable before that edge.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int l;
      l = lat_of(i);
      if (!rst_n) begin
        ph[i]  = -1;
        mc[i]  = 2'b00;
        mhp[i] = 32'd0;
      end else if (ph[i] >= 0) begin
        if (ph[i] == l) mhp[i] = {24'd0, mdat[7:0]};
        ph[i]++;
        if (ph[i] == l + 1) mdone[i]++;
        if (ph[i] > l + 1) ph[i] = -1;
      end else if (req && cause != 2'b00) begin
        ph[i] = 0;
        mc[i] = cause;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      int         l;
      logic [2:0] esel;
      logic [4:0] eflags;
      l      = lat_of(i);
      esel   = (ph[i] >= 0 && ph[i] <= l) ? sel_of(mc[i]) : 3'd0;
      eflags = {ph[i] >= 0, ph[i] == 0, ph[i] == l + 1, ph[i] == l + 1, 1'b0};
      chk("select", i, {29'd0, o_sel[i]}, {29'd0, esel});
      chk("busy_epc_pc_done_memwr", i,
          {27'd0, o_busy[i], o_epc[i], o_pc[i], o_done[i], o_memwr[i]}, {27'd0, eflags});
      chk("handler_pc", i, o_hp[i], mhp[i]);
      if (o_done[i] === 1'b1) ndone[i]++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Reset asserted between edges: outputs must clear without waiting for a clock.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    for (int i = 0; i < 3; i++) chk("async_rst_zero", i, {o_busy[i], o_pc[i], o_hp[i][29:0]}, 32'd0);
  endtask

  initial begin
    logic [7:0] rb;
    rst_n = 1'b1;
    req   = 1'b0;
    cause = 2'b00;
    mdat  = 32'd0;
    for (int i = 0; i < 3; i++) begin
      mdone[i] = 0;
      ndone[i] = 0;
    end
    model_reset();

    // Reset held: inputs toggling must not disturb anything.
    #2 rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req   = 1'b1;
      cause = 2'($urandom_range(1, 3));
      mdat  = $urandom;
      step();
    end
    req = 1'b0;
    rst_n = 1'b1;
    steps(2);

    // Overflow
    req = 1'b1; cause = 2'b01; mdat = 32'hABCD_12F0;
    step();
    req = 1'b0; cause = 2'b00;
    steps(8);
    for (int i = 0; i < 3; i++) chk("ovf_handler", i, o_hp[i], 32'h0000_00F0);

    // Invalid opcode
    req = 1'b1; cause = 2'b10; mdat = 32'h5555_AA7C;
    step();
    req = 1'b0;
    steps(8);
    for (int i = 0; i < 3; i++) chk("inv_handler", i, o_hp[i], 32'h0000_007C);

    // Divide by zero
    req = 1'b1; cause = 2'b11; mdat = 32'hFFFF_FF01;
    step();
    req = 1'b0;
    steps(8);
    for (int i = 0; i < 3; i++) chk("dbz_handler", i, o_hp[i], 32'h0000_0001);

    // Request with no cause is ignored
    req = 1'b1; cause = 2'b00; mdat = 32'h0000_0033;
    steps(3);
    for (int i = 0; i < 3; i++) chk("nocause_idle", i, {31'd0, o_busy[i]}, 32'd0);
    req = 1'b0;

    // Second request with a different cause while busy is dropped
    for (int i = 0; i < 3; i++) snap[i] = ndone[i];
    req = 1'b1; cause = 2'b01; mdat = 32'h0000_0042;
    step();
    cause = 2'b11;
    steps(2);
    req = 1'b0;
    steps(8);
    for (int i = 0; i < 3; i++) begin
      chk("busy_single_done", i, ndone[i] - snap[i], 32'd1);
      chk("busy_handler", i, o_hp[i], 32'h0000_0042);
    end

    // Reset in the middle of the wait window, then a clean request
    req = 1'b1; cause = 2'b10; mdat = 32'h0000_0099;
    step();
    req = 1'b0;
    step();
    chk("midwait_select", 0, {29'd0, o_sel[0]}, 32'd3);
    async_reset();
    steps(2);
    rst_n = 1'b1;
    steps(10);
    rb = 8'($urandom);
    req = 1'b1; cause = 2'b11; mdat = {24'hC0FFEE, rb};
    step();
    req = 1'b0;
    steps(8);
    for (int i = 0; i < 3; i++) chk("post_reset_handler", i, o_hp[i], {24'd0, rb});

    // Random traffic with occasional asynchronous resets
    for (int n = 0; n < 400; n++) begin
      req   = ($urandom_range(0, 2) == 0);
      cause = 2'($urandom);
      mdat  = $urandom;
      if ($urandom_range(0, 99) == 0) begin
        async_reset();
        step();
        rst_n = 1'b1;
      end
      step();
    end
    req = 1'b0;
    steps(8);
    for (int i = 0; i < 3; i++) chk("done_count", i, ndone[i], mdone[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exception_vector_reader.md
Name: exception_vector_reader

Overview:
Multicycle-control helper that fetches the exception handler address from memory when the datapath raises an exception. It drives the memory-address mux select to the cause's vector byte address (255/254/253) and waits the memory read latency. It then captures the returned byte, zero-extends it to 32 bits and issues single-cycle EPC-write and PC-write strobes. It sits beside the main control FSM, which hands over control on exc_req and resumes on exc_done.

Parameters:
MEM_LAT, 2, memory read latency in cycles from stable address to valid mem_data_in (legal 1..15)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
exc_req  input  1  exception request from control FSM, sampled only in IDLE
exc_cause  input  2  01 overflow, 10 invalid opcode, 11 divide-by-zero, 00 none
mem_data_in  input  32  memory read data bus
mux_mem_end  output  3  memory-address mux select: 000 PC, 010 addr 255, 011 addr 254, 100 addr 253
mem_wr  output  1  memory write enable, held 0 (read-only block)
epc_wr  output  1  one-cycle strobe: control latches EPC
pc_wr  output  1  one-cycle strobe: PC loads handler_pc
handler_pc  output  32  {24'd0, captured byte}
busy  output  1  high from ADDR through DONE inclusive
exc_done  output  1  one-cycle completion pulse, coincident with pc_wr

Behaviour:
- Reset (async assert, sync release): state IDLE; mux_mem_end=000, mem_wr=0, epc_wr=0, pc_wr=0, handler_pc=0, busy=0, exc_done=0, wait counter=0, latched cause=00.
- States: IDLE, ADDR, WAIT, CAPTURE, DONE.
- IDLE: mux_mem_end=000.
  - On a rising edge with exc_req=1 and exc_cause!=00: latch cause, go to ADDR, assert epc_wr for exactly the following cycle (the ADDR cycle).
  - exc_req with exc_cause=00 is ignored: remain IDLE, no strobes.
- ADDR: mux_mem_end = 010 / 011 / 100 for latched cause 01 / 10 / 11. Counter loaded with MEM_LAT-1. Next state WAIT; if MEM_LAT=1, go directly to CAPTURE.
- WAIT: select held. Counter decrements each cycle; at 0, go to CAPTURE.
- CAPTURE: select still held. handler_pc <= {24'd0, mem_data_in[7:0]}; bits 31:8 of mem_data_in are ignored. Next state DONE.
- DONE: mux_mem_end=000; pc_wr=1 and exc_done=1 for this single cycle; handler_pc stable. Next state IDLE.
- Select stability: mux_mem_end is registered and stays constant from ADDR through CAPTURE, so memory always sees one stable address for MEM_LAT cycles.
- Latency: request accepted at edge T; epc_wr high in cycle T+1; capture at edge T+1+MEM_LAT; pc_wr/exc_done high in cycle T+MEM_LAT+2. With MEM_LAT=2, exc_done arrives 4 cycles after acceptance.
- handler_pc persists until the next CAPTURE or reset.
- Requests or cause changes while busy=1 are ignored; no queueing. exc_req still high in DONE is not accepted; a new request is accepted only when sampled in IDLE, so back-to-back exceptions are spaced at least MEM_LAT+3 cycles apart.
- Reset asserted mid-sequence: immediate return to IDLE with all outputs at reset values. No pc_wr or exc_done may follow.
- All outputs are registered; none is combinational from inputs.

Test Plan:
- Reset: hold reset_n=0, toggle clock and inputs -> all outputs 0, mux_mem_end=000; release -> stays IDLE.
- Overflow, MEM_LAT=2: exc_req=1, cause=01, mem_data_in=32'hABCD_12F0 -> epc_wr one cycle; mux_mem_end=010 for 3 cycles; pc_wr/exc_done in the 4th cycle after acceptance; handler_pc=32'h0000_00F0.
- Invalid opcode and div-by-zero: cause=10 -> select 011; cause=11 -> select 100. mem_data_in=8'h7C and 8'h01 respectively -> handler_pc 32'h7C and 32'h01.
- cause=00 with exc_req=1 -> no state change, no strobes. Second request during busy with a different cause -> ignored, select unchanged, exactly one exc_done.
- Reset mid-WAIT: assert reset_n=0 while select=011 -> outputs zero immediately, no pc_wr ever issued; a fresh request afterwards completes normally.
- MEM_LAT=1 and MEM_LAT=5 builds: select held exactly MEM_LAT+1 cycles; exc_done at acceptance+MEM_LAT+2.
